// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multi-cycle core's memory responder.
// Consumed by mc_mem_responder and mc_mem_array.
package mc_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Any nonzero byte offset within a word is rejected.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Single-port synchronous word RAM with a per-byte write mask and registered read data.
// Contents are never reset.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic                  we,
    input  logic [BE_W-1:0]       mask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mc_mem_responder.sv
// Memory responder for the multi-cycle MIPS core: accepts a request, waits WAIT_CYCLES,
// then pulses ack for one cycle. Define MC_MEM_BYTE_EN to add the be byte-enable port.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
`ifdef MC_MEM_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: req is held by the initiator until ack; the request is taken on the
    // first rising edge in IDLE with req=1, and ack is high for exactly one cycle.

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;

    logic                  arr_re;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [WORD_W-1:0]     arr_rdata;
    logic [ADDR_WIDTH-1:0] word_in;
    logic [BE_W-1:0]       be_in;

    assign word_in = adr[ADDR_WIDTH+1:2];

`ifdef MC_MEM_BYTE_EN
    assign be_in = be;
`else
    assign be_in = '1;
`endif

    // Address bits above the array depth wrap and are deliberately dropped.
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        arr_re     = 1'b0;
        arr_we     = 1'b0;
        arr_addr   = word_q;
        case (state)
            IDLE: begin
                arr_addr = word_in;
                if (req) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
                arr_we     = we_q && !mis_q;
            end
            default: next_state = IDLE;
        endcase
        // Read data is captured on the edge that enters RESP.
        arr_re = (next_state == RESP) && (state != RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state == IDLE && req) begin
            cnt     <= CNT_W'(WAIT_CYCLES);
            we_q    <= we;
            mis_q   <= is_misaligned(adr[1:0]);
            word_q  <= word_in;
            wdata_q <= wdata;
            be_q    <= be_in;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    mc_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .re   (arr_re),
        .we   (arr_we),
        .mask (be_q),
        .addr (arr_addr),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    // Outputs depend only on registered state, never on the request inputs.
    assign ack       = (state == RESP);
    assign err       = ack && mis_q;
    assign rdata     = (ack && !we_q && !mis_q) ? arr_rdata : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: one instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
module tb_mc_mem_responder;

    logic        clk;
    logic        reset;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];
    logic [1:0]  dbg   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [31:0] model [64];

    mc_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .adr(adr[0]), .wdata(wdata[0]),
`ifdef MC_MEM_BYTE_EN
        .be(be[0]),
`endif
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]), .dbg_state(dbg[0])
    );

    mc_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .adr(adr[1]), .wdata(wdata[1]),
`ifdef MC_MEM_BYTE_EN
        .be(be[1]),
`endif
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]), .dbg_state(dbg[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every ack pops one expected {err, rdata}
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ack[s] === 1'b1) begin
                if (s == 0) begin
                    if (exp_q0.size() == 0) check("spurious_ack0", 1, 0);
                    else check("resp0", {err[0], rdata[0]}, exp_q0.pop_front());
                end else begin
                    if (exp_q1.size() == 0) check("spurious_ack1", 1, 0);
                    else check("resp1", {err[1], rdata[1]}, exp_q1.pop_front());
                end
            end
        end
    end

    // driver: one full access, scrambling the inputs while busy
    task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [32:0] exp, output int ack_cyc);
        int n;
        int lat;
        lat = (s == 0) ? 3 : 1;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; adr[s] = a; wdata[s] = d; be[s] = b;
        if (s == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
        @(posedge clk);
        #1;
        n = 1;
        while (ack[s] !== 1'b1 && n < 40) begin
            check("busy_wait", busy[s], 1);
            we[s] = 1'($urandom_range(0, 1));
            adr[s] = $urandom;
            wdata[s] = $urandom;
            be[s] = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("busy_ack", busy[s], 1);
        ack_cyc = cyc;
        req[s] = 1'b0;
        @(posedge clk);
        #1;
        check("busy_idle", busy[s], 0);
        check("ack_drop", ack[s], 0);
    endtask

    initial begin
        int t_a;
        int t_b;
        int t0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; we[s] = 0; adr[s] = 0; wdata[s] = 0; be[s] = 4'hF;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_ack", ack[s], 0);
            check("rst_err", err[s], 0);
            check("rst_busy", busy[s], 0);
            check("rst_rdata", rdata[s], 0);
            check("rst_state", dbg[s], 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // write then read, WAIT_CYCLES=2
        access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, {1'b0, 32'h0}, t_a);
        access(0, 0, 32'h10, 32'h0, 4'hF, {1'b0, 32'hDEADBEEF}, t_a);

        // misaligned accesses
        access(0, 0, 32'h13, 32'h0, 4'hF, {1'b1, 32'h0}, t_a);
        access(0, 1, 32'h12, 32'h55555555, 4'hF, {1'b1, 32'h0}, t_a);
        access(0, 0, 32'h10, 32'h0, 4'hF, {1'b0, 32'hDEADBEEF}, t_a);

        // high address bits wrap
        access(0, 1, 32'h400, 32'h11111111, 4'hF, {1'b0, 32'h0}, t_a);
        access(0, 0, 32'h000, 32'h0, 4'hF, {1'b0, 32'h11111111}, t_a);

        // reset in WAIT discards a pending write
        access(0, 1, 32'h20, 32'h0, 4'hF, {1'b0, 32'h0}, t_a);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
        @(posedge clk);
        #1;
        check("mid_busy", busy[0], 1);
        check("mid_state", dbg[0], 1);
        @(negedge clk);
        reset = 1'b1;
        req[0] = 1'b0;
        #1;
        check("async_busy", busy[0], 0);
        check("async_ack", ack[0], 0);
        check("async_state", dbg[0], 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        access(0, 0, 32'h20, 32'h0, 4'hF, {1'b0, 32'h0}, t_a);

`ifdef MC_MEM_BYTE_EN
        access(0, 1, 32'h20, 32'hAABBCCDD, 4'hF, {1'b0, 32'h0}, t_a);
        access(0, 1, 32'h20, 32'h11223344, 4'b0101, {1'b0, 32'h0}, t_a);
        access(0, 0, 32'h20, 32'h0, 4'hF, {1'b0, 32'hAA22CC44}, t_a);
        access(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, {1'b0, 32'h0}, t_a);
        access(0, 0, 32'h20, 32'h0, 4'hF, {1'b0, 32'hAA22CC44}, t_a);
`endif

        // WAIT_CYCLES=0: back-to-back reads finish within four cycles
        access(1, 1, 32'h40, 32'h01234567, 4'hF, {1'b0, 32'h0}, t_a);
        access(1, 1, 32'h44, 32'h89ABCDEF, 4'hF, {1'b0, 32'h0}, t_a);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h40;
        exp_q1.push_back({1'b0, 32'h01234567});
        @(posedge clk);
        #1;
        t0 = cyc;
        check("z_lat_ack", ack[1], 1);
        req[1] = 1'b0;
        @(negedge clk);
        req[1] = 1'b1; adr[1] = 32'h44;
        exp_q1.push_back({1'b0, 32'h89ABCDEF});
        @(posedge clk);
        #1;
        check("z_accept_blocked", ack[1], 0);
        @(posedge clk);
        #1;
        t_b = cyc;
        check("z_b2b_ack", ack[1], 1);
        check("z_b2b_cycles", t_b - t0, 2);
        req[1] = 1'b0;
        @(posedge clk);

        // random words through the zero-wait instance against a model
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            access(1, 1, 32'h100 + 32'(4 * i), model[i], 4'hF, {1'b0, 32'h0}, t_a);
        end
        for (int i = 7; i >= 0; i--) begin
            access(1, 0, 32'h100 + 32'(4 * i), 32'h0, 4'hF, {1'b0, model[i]}, t_a);
        end

        repeat (4) @(posedge clk);
        #1;
        check("drain0", exp_q0.size(), 0);
        check("drain1", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
